// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage vector ALU.
//   DATA_W      - datapath width (64)
//   VEC_OPCODE  - the only opcode the ALU executes (vector R-type)
//   func_e      - vector function codes
//   ww_e        - lane width encodings
//   helpers     - function-code legality and multiply classification
package alu_pkg;

  localparam int DATA_W = 64;
  localparam logic [5:0] VEC_OPCODE = 6'b101010;

  typedef enum logic [5:0] {
    FN_VAND   = 6'b000001,
    FN_VOR    = 6'b000010,
    FN_VXOR   = 6'b000011,
    FN_VNOT   = 6'b000100,
    FN_VMOV   = 6'b000101,
    FN_VADD   = 6'b000110,
    FN_VSUB   = 6'b000111,
    FN_VMULEU = 6'b001000,
    FN_VMULOU = 6'b001001,
    FN_VSLL   = 6'b001010,
    FN_VSRL   = 6'b001011,
    FN_VSRA   = 6'b001100,
    FN_VRTTH  = 6'b001101
  } func_e;

  typedef enum logic [1:0] {
    WW_8  = 2'b00,
    WW_16 = 2'b01,
    WW_32 = 2'b10,
    WW_64 = 2'b11
  } ww_e;

  // True for every implemented function code.
  function automatic logic is_vec_func(input logic [5:0] fn);
    logic ok;
    case (fn)
      6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
      6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001010,
      6'b001011, 6'b001100, 6'b001101: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True for the widening multiplies, which have no 64-bit lane form.
  function automatic logic is_mul_func(input logic [5:0] fn);
    return (fn == 6'b001000) || (fn == 6'b001001);
  endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: ID/EX-to-ALU-to-EX/MEM signal bundle.
//   ID_EX_Instr, rA_data, rB_data, in_valid - driven by the pipeline (master)
//   ALU_out, out_valid, illegal             - driven by the ALU (slave)
interface alu_if;
  import alu_pkg::*;

  logic [31:0]       ID_EX_Instr;
  logic [DATA_W-1:0] rA_data;
  logic [DATA_W-1:0] rB_data;
  logic              in_valid;
  logic [DATA_W-1:0] ALU_out;
  logic              out_valid;
  logic              illegal;

  modport master (
    output ID_EX_Instr, rA_data, rB_data, in_valid,
    input  ALU_out, out_valid, illegal
  );

  modport slave (
    input  ID_EX_Instr, rA_data, rB_data, in_valid,
    output ALU_out, out_valid, illegal
  );
endinterface

// File: rtl/alu_lane_unit.sv
// alu_lane_unit: purely combinational lane datapath.
//   ww     in  2   lane width select
//   func   in  6   function code
//   a, b   in  64  source operands
//   result out 64  lane-wise result (0 for unknown functions)
// Every lane width is computed in parallel and the selected one is muxed
// out, so no carry, borrow or shift can cross a lane boundary.
module alu_lane_unit
  import alu_pkg::*;
(
  input  logic [1:0]        ww,
  input  func_e             func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] width_res_s [4];
  logic [DATA_W-1:0] mul_res_s   [4];

  for (genvar gw = 0; gw < 4; gw++) begin : g_width
    localparam int W  = 8 << gw;
    localparam int N  = DATA_W / W;
    localparam int SW = 3 + gw;

    logic [DATA_W-1:0] lane_res_s;
    logic [DATA_W-1:0] pair_res_s;

    for (genvar gl = 0; gl < N; gl++) begin : g_lane
      logic [W-1:0]  a_s;
      logic [W-1:0]  b_s;
      logic [W-1:0]  r_s;
      logic [SW-1:0] sh_s;

      assign a_s  = a[gl*W +: W];
      assign b_s  = b[gl*W +: W];
      assign sh_s = b_s[SW-1:0];

      // Per-lane add/sub/shift/half-swap for this lane width.
      always_comb begin
        r_s = {W{1'b0}};
        case (func)
          FN_VADD:  r_s = a_s + b_s;
          FN_VSUB:  r_s = a_s - b_s;
          FN_VSLL:  r_s = a_s << sh_s;
          FN_VSRL:  r_s = a_s >> sh_s;
          FN_VSRA:  r_s = $unsigned($signed(a_s) >>> sh_s);
          FN_VRTTH: r_s = {a_s[W/2-1:0], a_s[W-1:W/2]};
          default:  r_s = {W{1'b0}};
        endcase
      end

      assign lane_res_s[gl*W +: W] = r_s;
    end

    if (gw < 3) begin : g_mul
      // Each lane pair (2k, 2k+1) receives one double-width product.
      for (genvar gp = 0; gp < N/2; gp++) begin : g_pair
        logic [2*W-1:0] prod_e_s;
        logic [2*W-1:0] prod_o_s;

        assign prod_e_s = {{W{1'b0}}, a[2*gp*W +: W]} * {{W{1'b0}}, b[2*gp*W +: W]};
        assign prod_o_s = {{W{1'b0}}, a[(2*gp+1)*W +: W]} * {{W{1'b0}}, b[(2*gp+1)*W +: W]};
        assign pair_res_s[2*gp*W +: 2*W] = (func == FN_VMULOU) ? prod_o_s : prod_e_s;
      end
    end else begin : g_nomul
      assign pair_res_s = {DATA_W{1'b0}};
    end

    assign width_res_s[gw] = lane_res_s;
    assign mul_res_s[gw]   = pair_res_s;
  end

  // Final function select; bitwise ops are width-independent.
  always_comb begin
    result = {DATA_W{1'b0}};
    case (func)
      FN_VAND:  result = a & b;
      FN_VOR:   result = a | b;
      FN_VXOR:  result = a ^ b;
      FN_VNOT:  result = ~a;
      FN_VMOV:  result = a;
      FN_VADD, FN_VSUB, FN_VSLL, FN_VSRL, FN_VSRA, FN_VRTTH:
                result = width_res_s[ww];
      FN_VMULEU, FN_VMULOU:
                result = mul_res_s[ww];
      default:  result = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: execute-stage vector ALU top level.
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  alu_if.slave: instruction/operands/in_valid in;
//        ALU_out/out_valid/illegal out, all registered (1-cycle latency)
// Contains decode, the illegal-instruction check and the output registers;
// the datapath lives in alu_lane_unit.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [5:0]        opcode_s;
  logic [2:0]        zero_field_s;
  logic [1:0]        ww_s;
  logic [5:0]        func_raw_s;
  func_e             func_s;
  logic              legal_s;
  logic [DATA_W-1:0] lane_res_s;
  logic              unused_reg_fields_s;

  logic [DATA_W-1:0] alu_out_r;
  logic              out_valid_r;
  logic              illegal_r;

  assign opcode_s     = bus.ID_EX_Instr[31:26];
  assign zero_field_s = bus.ID_EX_Instr[10:8];
  assign ww_s         = bus.ID_EX_Instr[7:6];
  assign func_raw_s   = bus.ID_EX_Instr[5:0];
  assign func_s       = func_e'(func_raw_s);

  // Register numbers are resolved before this stage.
  assign unused_reg_fields_s = ^bus.ID_EX_Instr[25:11];

  // Legal only for the vector opcode, reserved field clear, known function,
  // and not a widening multiply at 64-bit lane width.
  always_comb begin
    legal_s = 1'b0;
    if ((opcode_s == VEC_OPCODE) && (zero_field_s == 3'b000) && is_vec_func(func_raw_s)) begin
      legal_s = !(is_mul_func(func_raw_s) && (ww_s == WW_64));
    end else begin
      legal_s = 1'b0;
    end
  end

  alu_lane_unit u_lane_unit (
    .ww     (ww_s),
    .func   (func_s),
    .a      (bus.rA_data),
    .b      (bus.rB_data),
    .result (lane_res_s)
  );

  // Output registers: reset wins; idle cycles hold result and illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_r   <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        alu_out_r <= legal_s ? lane_res_s : {DATA_W{1'b0}};
        illegal_r <= !legal_s;
      end
    end
  end

  assign bus.ALU_out   = alu_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.illegal   = illegal_r;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  typedef struct {
    logic        v;
    logic        ill;
    logic [63:0] out;
  } exp_t;

  logic clk;
  logic rst;
  alu_if bus();

  alu dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [63:0] last_out;
  logic        last_ill;

  function automatic logic [31:0] mk(input logic [5:0] fn, input logic [1:0] ww);
    return {6'b101010, 15'd0, 3'b000, ww, fn};
  endfunction

  // Independent reference: element-by-element arithmetic on 64-bit values.
  function automatic void ref_model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic ill);
    int w, n, sh;
    logic [63:0] mask, dmask, ea, eb, e;
    logic [5:0] fn;
    w = 8 << ins[7:6];
    n = 64 / w;
    fn = ins[5:0];
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    dmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
    r = 64'd0;
    ill = 1'b0;
    if (ins[31:26] != 6'b101010 || ins[10:8] != 3'b000) begin
      ill = 1'b1;
    end else begin
      case (fn)
        6'd1: r = a & b;
        6'd2: r = a | b;
        6'd3: r = a ^ b;
        6'd4: r = ~a;
        6'd5: r = a;
        6'd6, 6'd7, 6'd10, 6'd11, 6'd12, 6'd13: begin
          for (int i = 0; i < n; i++) begin
            ea = (a >> (i*w)) & mask;
            eb = (b >> (i*w)) & mask;
            sh = int'(eb % w);
            case (fn)
              6'd6:  e = (ea + eb) & mask;
              6'd7:  e = (ea - eb) & mask;
              6'd10: e = (ea << sh) & mask;
              6'd11: e = ea >> sh;
              6'd12: e = ea[w-1] ? ((ea >> sh) | (mask & ~(mask >> sh))) : (ea >> sh);
              default: e = ((ea >> (w/2)) | (ea << (w/2))) & mask;
            endcase
            r = r | (e << (i*w));
          end
        end
        6'd8, 6'd9: begin
          if (w == 64) begin
            ill = 1'b1;
          end else begin
            for (int k = 0; k < n/2; k++) begin
              ea = (a >> ((2*k + int'(fn[0]))*w)) & mask;
              eb = (b >> ((2*k + int'(fn[0]))*w)) & mask;
              r = r | (((ea * eb) & dmask) << (2*k*w));
            end
          end
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) r = 64'd0;
  endfunction

  // Drive one cycle, push the expectation, advance past the edge.
  task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b, input logic v,
                       input logic use_const, input logic [63:0] c_out, input logic c_ill);
    exp_t e;
    logic [63:0] m_out;
    logic m_ill;
    bus.ID_EX_Instr = ins;
    bus.rA_data = a;
    bus.rB_data = b;
    bus.in_valid = v;
    if (rst) begin
      last_out = 64'd0;
      last_ill = 1'b0;
      e = '{v: 1'b0, ill: 1'b0, out: 64'd0};
    end else if (v) begin
      if (use_const) begin
        m_out = c_out;
        m_ill = c_ill;
      end else begin
        ref_model(ins, a, b, m_out, m_ill);
      end
      last_out = m_out;
      last_ill = m_ill;
      e = '{v: 1'b1, ill: m_ill, out: m_out};
    end else begin
      e = '{v: 1'b0, ill: last_ill, out: last_out};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      rst = (i != 1);
      issue(mk(6'd3, 2'b00), 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0, 64'd0, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.out_valid !== e.v) begin errors++; $display("FAIL reset[%0d] out_valid got %0b want %0b", i, bus.out_valid, e.v); end
      checks++; if (bus.ALU_out !== e.out) begin errors++; $display("FAIL reset[%0d] ALU_out got %h want %h", i, bus.ALU_out, e.out); end
      checks++; if (bus.illegal !== e.ill) begin errors++; $display("FAIL reset[%0d] illegal got %0b want %0b", i, bus.illegal, e.ill); end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    exp_t e;
    logic [31:0] ins [8];
    logic [63:0] av [8];
    logic [63:0] bv [8];
    logic [63:0] xo [8];
    logic        xi [8];
    ins[0] = 32'hA800_0041; av[0] = 64'hFF00FF00F0F0F0F0; bv[0] = 64'h0FF00FF0FFFF0000; xo[0] = 64'h0F000F00F0F00000; xi[0] = 1'b0;
    ins[1] = mk(6'd6, 2'b00); av[1] = 64'hFF01010101010101; bv[1] = 64'h0101010101010101; xo[1] = 64'h0002020202020202; xi[1] = 1'b0;
    ins[2] = mk(6'd7, 2'b11); av[2] = 64'd0; bv[2] = 64'd1; xo[2] = 64'hFFFFFFFFFFFFFFFF; xi[2] = 1'b0;
    ins[3] = mk(6'd12, 2'b10); av[3] = 64'h8000000000000010; bv[3] = 64'h0000000400000001; xo[3] = 64'hF800000000000008; xi[3] = 1'b0;
    ins[4] = mk(6'd8, 2'b10); av[4] = 64'h00000000FFFFFFFF; bv[4] = 64'h0000000000000002; xo[4] = 64'h00000001FFFFFFFE; xi[4] = 1'b0;
    ins[5] = mk(6'd9, 2'b11); av[5] = 64'h1111111111111111; bv[5] = 64'h2222222222222222; xo[5] = 64'd0; xi[5] = 1'b1;
    ins[6] = mk(6'd13, 2'b00); av[6] = 64'h0123456789ABCDEF; bv[6] = 64'd0; xo[6] = 64'h1032547698BADCFE; xi[6] = 1'b0;
    ins[7] = mk(6'd9, 2'b01); av[7] = 64'h0003_0000_0002_0000; bv[7] = 64'hFFFF_0000_0005_0000; xo[7] = 64'h0002FFFD0000000A; xi[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue(ins[i], av[i], bv[i], 1'b1, 1'b1, xo[i], xi[i]);
      e = sb.pop_front();
      checks++; if (bus.out_valid !== e.v) begin errors++; $display("FAIL directed[%0d] out_valid got %0b want %0b", i, bus.out_valid, e.v); end
      checks++; if (bus.ALU_out !== e.out) begin errors++; $display("FAIL directed[%0d] ALU_out got %h want %h", i, bus.ALU_out, e.out); end
      checks++; if (bus.illegal !== e.ill) begin errors++; $display("FAIL directed[%0d] illegal got %0b want %0b", i, bus.illegal, e.ill); end
    end
  endtask

  task automatic test_illegal_hold();
    exp_t e;
    logic [31:0] ins [7];
    logic        vv  [7];
    ins[0] = mk(6'd3, 2'b00);          vv[0] = 1'b1;
    ins[1] = 32'h0000_0000;            vv[1] = 1'b0;
    ins[2] = 32'hFFFF_FFFF;            vv[2] = 1'b0;
    ins[3] = 32'h0000_0041;            vv[3] = 1'b1;
    ins[4] = mk(6'd3, 2'b00);          vv[4] = 1'b0;
    ins[5] = mk(6'd3, 2'b00);          vv[5] = 1'b0;
    ins[6] = mk(6'd1, 2'b00) | 32'h100; vv[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      issue(ins[i], 64'hDEAD_BEEF_0000_FFFF, 64'h0F0F_0F0F_F0F0_F0F0, vv[i], 1'b0, 64'd0, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.out_valid !== e.v) begin errors++; $display("FAIL illhold[%0d] out_valid got %0b want %0b", i, bus.out_valid, e.v); end
      checks++; if (bus.ALU_out !== e.out) begin errors++; $display("FAIL illhold[%0d] ALU_out got %h want %h", i, bus.ALU_out, e.out); end
      checks++; if (bus.illegal !== e.ill) begin errors++; $display("FAIL illhold[%0d] illegal got %0b want %0b", i, bus.illegal, e.ill); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] ins;
    logic [5:0]  fn;
    logic        v;
    for (int i = 0; i < 200; i++) begin
      fn = 6'($urandom_range(1, 13));
      if ((i % 23) == 7) fn = 6'($urandom_range(14, 63));
      ins = mk(fn, 2'($urandom_range(0, 3)));
      v = ($urandom_range(0, 7) != 0);
      issue(ins, {$urandom, $urandom}, {$urandom, $urandom}, v, 1'b0, 64'd0, 1'b0);
      e = sb.pop_front();
      checks++; if (bus.out_valid !== e.v) begin errors++; $display("FAIL b2b[%0d] out_valid got %0b want %0b", i, bus.out_valid, e.v); end
      checks++; if (bus.ALU_out !== e.out) begin errors++; $display("FAIL b2b[%0d] ins %h ALU_out got %h want %h", i, ins, bus.ALU_out, e.out); end
      checks++; if (bus.illegal !== e.ill) begin errors++; $display("FAIL b2b[%0d] illegal got %0b want %0b", i, bus.illegal, e.ill); end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    last_out = 64'd0;
    last_ill = 1'b0;
    bus.ID_EX_Instr = 32'd0;
    bus.rA_data = 64'd0;
    bus.rB_data = 64'd0;
    bus.in_valid = 1'b0;
    test_reset();
    test_directed();
    test_illegal_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
